// File: rtl/pcileech_tlp_pkg.sv
// Shared TLP framing constants, the receive write-state enum and the 66-bit beat packing helper.
package pcileech_tlp_pkg;

    localparam int TLP64_BEATS = 6;
    localparam int TLP_BEAT_W  = 66;
    localparam int TLP64_W     = TLP64_BEATS * TLP_BEAT_W;
    localparam int BEAT_LAST   = 64;
    localparam int BEAT_KEEP2  = 65;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DROP
    } wr_state_e;

    // Only the upper keep nibble matters: it tells whether the second DW of the beat is valid.
    function automatic logic [TLP_BEAT_W-1:0] packBeat(
        input logic [63:0] data,
        input logic [7:0]  keep,
        input logic        last
    );
        logic [TLP_BEAT_W-1:0] beat;
        beat             = '0;
        beat[63:0]       = data;
        beat[BEAT_LAST]  = last;
        beat[BEAT_KEEP2] = (keep[7:4] == 4'hF);
        return beat;
    endfunction

endpackage

// File: rtl/pcileech_tlp64_slot.sv
// One 396-bit TLP storage slot: zero-fill, indexed beat write and a full flag.
module pcileech_tlp64_slot
    import pcileech_tlp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  wrEn_i,
    input  logic [2:0]            wrIdx_i,
    input  logic [TLP_BEAT_W-1:0] wrBeat_i,
    input  logic                  setFull_i,
    input  logic                  clrFull_i,
    output logic [TLP64_W-1:0]    data_o,
    output logic                  full_o
);

    logic [TLP64_W-1:0] data_q, data_d;
    logic               full_q, full_d;

    // Clear and write may coincide on beat 0 so the unused tail entries read back as zero.
    always_comb begin
        data_d = clear_i ? '0 : data_q;
        if (wrEn_i) begin
            for (int b = 0; b < TLP64_BEATS; b++) begin
                if (wrIdx_i == 3'(b)) begin
                    data_d[b*TLP_BEAT_W +: TLP_BEAT_W] = wrBeat_i;
                end
            end
        end
        full_d = full_q;
        if (setFull_i) begin
            full_d = 1'b1;
        end else if (clrFull_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/pcileech_tlp64_rx_packer.sv
// Packs 64-bit AXI-stream TLP beats into double-buffered 6x66-bit TLP slots and drops oversize TLPs.
// Optional macro PCILEECH_TLP64_DROPCNT_EN enables the saturating drop counter (else drop count reads 0).
module pcileech_tlp64_rx_packer
    import pcileech_tlp_pkg::*;
#(
    parameter int NUM_SLOTS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [63:0]        tlpRxData_i,
    input  logic [7:0]         tlpRxKeep_i,
    input  logic               tlpRxLast_i,
    input  logic               tlpRxValid_i,
    output logic               tlpRxReady_o,
    output logic [TLP64_W-1:0] tlpOutData_o,
    output logic               tlpOutValid_o,
    output logic               tlpOutHasData_o,
    input  logic               tlpOutReqData_i,
    output logic [15:0]        dropCount_o
);

    wr_state_e          state_q, state_d;
    logic [2:0]         beatCnt_q, beatCnt_d;
    logic               wrPtr_q, wrPtr_d;
    logic               rdPtr_q, rdPtr_d;
    logic               outValid_q, outValid_d;

    logic               beatAccept;
    logic               wrClear;
    logic               wrEn;
    logic               wrSetFull;
    logic               dropEvt;
    logic               reqAccept;

    logic [NUM_SLOTS-1:0] slotFull;
    logic [TLP64_W-1:0]   slotData [NUM_SLOTS];

    assign tlpRxReady_o = !rst && ((state_q == DROP) || !slotFull[wrPtr_q]);
    assign beatAccept   = tlpRxValid_i && tlpRxReady_o;

    // Write-side FSM: beat 0 zero-fills the slot; a 7th beat aborts the TLP and scrubs the slot.
    always_comb begin
        state_d   = state_q;
        beatCnt_d = beatCnt_q;
        wrPtr_d   = wrPtr_q;
        wrClear   = 1'b0;
        wrEn      = 1'b0;
        wrSetFull = 1'b0;
        dropEvt   = 1'b0;
        if (beatAccept) begin
            case (state_q)
                IDLE: begin
                    wrClear = 1'b1;
                    wrEn    = 1'b1;
                    if (tlpRxLast_i) begin
                        wrSetFull = 1'b1;
                        wrPtr_d   = (NUM_SLOTS == 1) ? 1'b0 : ~wrPtr_q;
                        beatCnt_d = 3'd0;
                    end else begin
                        state_d   = FILL;
                        beatCnt_d = 3'd1;
                    end
                end
                FILL: begin
                    if (beatCnt_q == 3'(TLP64_BEATS)) begin
                        dropEvt   = 1'b1;
                        wrClear   = 1'b1;
                        beatCnt_d = 3'd0;
                        state_d   = tlpRxLast_i ? IDLE : DROP;
                    end else begin
                        wrEn = 1'b1;
                        if (tlpRxLast_i) begin
                            wrSetFull = 1'b1;
                            wrPtr_d   = (NUM_SLOTS == 1) ? 1'b0 : ~wrPtr_q;
                            beatCnt_d = 3'd0;
                            state_d   = IDLE;
                        end else begin
                            beatCnt_d = beatCnt_q + 3'd1;
                        end
                    end
                end
                DROP: begin
                    if (tlpRxLast_i) begin
                        state_d   = IDLE;
                        beatCnt_d = 3'd0;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    beatCnt_d = 3'd0;
                end
            endcase
        end
    end

    // Read side: a request is taken only when data is waiting and no pulse is already out;
    // the slot is released during the valid cycle itself.
    always_comb begin
        reqAccept  = tlpOutHasData_o && tlpOutReqData_i && !outValid_q;
        outValid_d = reqAccept;
        rdPtr_d    = rdPtr_q;
        if (outValid_q) begin
            rdPtr_d = (NUM_SLOTS == 1) ? 1'b0 : ~rdPtr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beatCnt_q  <= 3'd0;
            wrPtr_q    <= 1'b0;
            rdPtr_q    <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beatCnt_q  <= beatCnt_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            outValid_q <= outValid_d;
        end
    end

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : gSlot
        pcileech_tlp64_slot uSlot (
            .clk       (clk),
            .rst       (rst),
            .clear_i   (wrClear && (wrPtr_q == 1'(s))),
            .wrEn_i    (wrEn && (wrPtr_q == 1'(s))),
            .wrIdx_i   (beatCnt_q),
            .wrBeat_i  (packBeat(tlpRxData_i, tlpRxKeep_i, tlpRxLast_i)),
            .setFull_i (wrSetFull && (wrPtr_q == 1'(s))),
            .clrFull_i (outValid_q && (rdPtr_q == 1'(s))),
            .data_o    (slotData[s]),
            .full_o    (slotFull[s])
        );
    end

    assign tlpOutHasData_o = slotFull[rdPtr_q];
    assign tlpOutValid_o   = outValid_q;
    assign tlpOutData_o    = slotData[rdPtr_q];

`ifdef PCILEECH_TLP64_DROPCNT_EN
    logic [15:0] dropCnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dropCnt_q <= 16'h0;
        end else if (dropEvt && (dropCnt_q != 16'hFFFF)) begin
            dropCnt_q <= dropCnt_q + 16'h1;
        end
    end

    assign dropCount_o = dropCnt_q;
`else
    logic unusedDropEvt;
    assign unusedDropEvt = dropEvt;
    assign dropCount_o   = 16'h0;
`endif

endmodule

// File: tb/tb_pcileech_tlp64_rx_packer.sv
// Directed bench for pcileech_tlp64_rx_packer: framing, latency, backpressure, oversize drop and reset.
module tb_pcileech_tlp64_rx_packer;
    import pcileech_tlp_pkg::*;

`ifdef PCILEECH_TLP64_DROPCNT_EN
    localparam logic [15:0] EXP_DROP1 = 16'd1;
    localparam logic [15:0] EXP_DROP2 = 16'd2;
`else
    localparam logic [15:0] EXP_DROP1 = 16'd0;
    localparam logic [15:0] EXP_DROP2 = 16'd0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [63:0]        tlpRxData;
    logic [7:0]         tlpRxKeep;
    logic               tlpRxLast;
    logic               tlpRxValid;
    logic               tlpRxReady;
    logic [TLP64_W-1:0] tlpOutData;
    logic               tlpOutValid;
    logic               tlpOutHasData;
    logic               tlpOutReqData;
    logic [15:0]        dropCount;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pcileech_tlp64_rx_packer #(.NUM_SLOTS(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .tlpRxData_i     (tlpRxData),
        .tlpRxKeep_i     (tlpRxKeep),
        .tlpRxLast_i     (tlpRxLast),
        .tlpRxValid_i    (tlpRxValid),
        .tlpRxReady_o    (tlpRxReady),
        .tlpOutData_o    (tlpOutData),
        .tlpOutValid_o   (tlpOutValid),
        .tlpOutHasData_o (tlpOutHasData),
        .tlpOutReqData_i (tlpOutReqData),
        .dropCount_o     (dropCount)
    );

    function automatic logic [65:0] mkBeat(input logic [63:0] d, input logic [7:0] k, input logic l);
        return {(k[7:4] == 4'hF), l, d};
    endfunction

    function automatic logic [63:0] beatData(input logic [7:0] tag, input int b);
        return {tag, 8'(b), 16'hBEEF, 8'h5A, tag, 8'(b), 8'hC3};
    endfunction

    task automatic checkOutput(input string tag, input logic [TLP64_W-1:0] obs, input logic [TLP64_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one beat from a negedge and returns on the negedge after it is accepted.
    task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k, input logic l);
        int cyc;
        tlpRxData  = d;
        tlpRxKeep  = k;
        tlpRxLast  = l;
        tlpRxValid = 1'b1;
        cyc = 0;
        while (!tlpRxReady && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) checkOutput("readyTimeout", 396'(tlpRxReady), 396'(1));
        @(negedge clk);
        tlpRxValid = 1'b0;
    endtask

    task automatic sendTlp(input int n, input logic [7:0] tag, input logic [7:0] lastKeep,
                           output logic [TLP64_W-1:0] exp);
        logic [7:0] k;
        exp = '0;
        for (int b = 0; b < n; b++) begin
            k = (b == n - 1) ? lastKeep : 8'hFF;
            if (b < TLP64_BEATS) exp[b*66 +: 66] = mkBeat(beatData(tag, b), k, b == n - 1);
            applyStimulus(beatData(tag, b), k, b == n - 1);
        end
        if (n > TLP64_BEATS) exp = '0;
    endtask

    task automatic requestTlp(input string tag, input logic [TLP64_W-1:0] exp);
        checkOutput({tag, "HasData"}, 396'(tlpOutHasData), 396'(1));
        tlpOutReqData = 1'b1;
        @(negedge clk);
        tlpOutReqData = 1'b0;
        checkOutput({tag, "Valid"}, 396'(tlpOutValid), 396'(1));
        checkOutput({tag, "Data"}, tlpOutData, exp);
        @(negedge clk);
        checkOutput({tag, "ValidDrop"}, 396'(tlpOutValid), 396'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [TLP64_W-1:0] e1, eA, eB, eC;

        rst           = 1'b1;
        tlpRxData     = '0;
        tlpRxKeep     = '0;
        tlpRxLast     = 1'b0;
        tlpRxValid    = 1'b0;
        tlpOutReqData = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstReady", 396'(tlpRxReady), 396'(0));
        checkOutput("rstValid", 396'(tlpOutValid), 396'(0));
        checkOutput("rstHasData", 396'(tlpOutHasData), 396'(0));
        checkOutput("rstData", tlpOutData, '0);
        checkOutput("rstDrop", 396'(dropCount), 396'(0));
        rst = 1'b0;
        #1;
        checkOutput("postRstReady", 396'(tlpRxReady), 396'(1));
        @(negedge clk);

        // 3DW MRd, 2 beats, last keep 0F
        sendTlp(2, 8'h01, 8'h0F, e1);
        checkOutput("mrdLatency", 396'(tlpOutHasData), 396'(1));
        requestTlp("mrd", e1);
        checkOutput("mrdEmpty", 396'(tlpOutHasData), 396'(0));

        // 4DW MWr, 6 beats, keep FF throughout
        sendTlp(6, 8'h02, 8'hFF, e1);
        checkOutput("mwrLatency", 396'(tlpOutHasData), 396'(1));
        requestTlp("mwr", e1);

        // 7-beat and 8-beat TLPs are dropped, then a 2-beat TLP passes intact
        sendTlp(7, 8'h03, 8'hFF, e1);
        checkOutput("drop7HasData", 396'(tlpOutHasData), 396'(0));
        checkOutput("drop7Count", 396'(dropCount), 396'(EXP_DROP1));
        sendTlp(8, 8'h04, 8'hFF, e1);
        checkOutput("drop8HasData", 396'(tlpOutHasData), 396'(0));
        checkOutput("drop8Count", 396'(dropCount), 396'(EXP_DROP2));
        sendTlp(2, 8'h05, 8'h0F, e1);
        requestTlp("afterDrop", e1);

        // Fill both slots, hold the third TLP's first beat under backpressure
        sendTlp(2, 8'h10, 8'hFF, eA);
        sendTlp(2, 8'h11, 8'h0F, eB);
        checkOutput("fullReady", 396'(tlpRxReady), 396'(0));
        eC = '0;
        eC[65:0]   = mkBeat(beatData(8'h12, 0), 8'hFF, 1'b0);
        eC[131:66] = mkBeat(beatData(8'h12, 1), 8'hF0, 1'b1);
        tlpRxData  = beatData(8'h12, 0);
        tlpRxKeep  = 8'hFF;
        tlpRxLast  = 1'b0;
        tlpRxValid = 1'b1;
        @(negedge clk);
        checkOutput("fullHold", 396'(tlpRxReady), 396'(0));
        requestTlp("fullA", eA);
        checkOutput("freedReady", 396'(tlpRxReady), 396'(1));
        @(negedge clk);
        applyStimulus(beatData(8'h12, 1), 8'hF0, 1'b1);

        // Held request: second delivery two cycles after the first
        tlpOutReqData = 1'b1;
        @(negedge clk);
        checkOutput("b2bValidB", 396'(tlpOutValid), 396'(1));
        checkOutput("b2bDataB", tlpOutData, eB);
        @(negedge clk);
        checkOutput("b2bGap", 396'(tlpOutValid), 396'(0));
        @(negedge clk);
        tlpOutReqData = 1'b0;
        checkOutput("b2bValidC", 396'(tlpOutValid), 396'(1));
        checkOutput("b2bDataC", tlpOutData, eC);
        @(negedge clk);
        checkOutput("b2bEnd", 396'(tlpOutValid), 396'(0));
        checkOutput("b2bEmpty", 396'(tlpOutHasData), 396'(0));

        // Reset in the middle of a 3-beat TLP
        applyStimulus(beatData(8'h20, 0), 8'hFF, 1'b0);
        applyStimulus(beatData(8'h20, 1), 8'hFF, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRstReady", 396'(tlpRxReady), 396'(0));
        checkOutput("midRstHasData", 396'(tlpOutHasData), 396'(0));
        checkOutput("midRstDrop", 396'(dropCount), 396'(0));
        checkOutput("midRstData", tlpOutData, '0);
        rst = 1'b0;
        @(negedge clk);
        sendTlp(2, 8'h21, 8'h0F, e1);
        requestTlp("postRst", e1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
